// File: rtl/uart_fifo_link_if.sv
// uart_fifo_link_if: byte-stream side of the UART link.
//   master : the consumer/producer logic (drives tx_data/tx_valid/rx_ready)
//   slave  : the UART link itself (drives ready/valid/data/status back)
// Signals:
//   tx_data/tx_valid/tx_ready : TX FIFO write handshake
//   rx_data/rx_valid/rx_ready : RX FIFO show-ahead read handshake
//   parity_err/frame_err/overrun : one-cycle receive status pulses
//   tx_level/rx_level : FIFO occupancies
interface uart_fifo_link_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic [LW-1:0]        tx_level;
    logic [LW-1:0]        rx_level;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, parity_err, frame_err, overrun,
               tx_level, rx_level
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, parity_err, frame_err, overrun,
               tx_level, rx_level
    );
endinterface

// File: rtl/uart_fifo_link.sv
// uart_fifo_link: full-duplex UART with TX and RX FIFOs, 5..8 data bits,
// optional odd/even parity, 16x oversampling and receive error pulses.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   rx    : serial input (asynchronous, synchronised internally)
//   tx    : serial output, idle high
//   bus   : byte-stream handshakes, status pulses and FIFO levels
module uart_fifo_link #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic tx,
    uart_fifo_link_if.slave bus
);
    localparam int OVS_RAW = CLK_HZ / (BAUD * 16);
    localparam int OVS_DIV = (OVS_RAW < 1) ? 1 : OVS_RAW;
    localparam int CW      = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int BCW     = $clog2(DATA_BITS) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) return ~(^d);
        return ^d;
    endfunction

    // ---------------- oversampling tick ----------------
    logic [CW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == CW'(OVS_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CW'(1);
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] txf_mem [FIFO_DEPTH];
    logic [LW-1:0]        txf_wptr, txf_rptr, txf_level;
    logic                 txf_full, txf_empty, txf_push, txf_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign txf_level    = txf_wptr - txf_rptr;
    assign txf_full     = (txf_level == LW'(FIFO_DEPTH));
    assign txf_empty    = (txf_level == '0);
    assign txf_push     = bus.tx_valid && !txf_full;
    assign tx_head      = txf_mem[txf_rptr[AW-1:0]];
    assign bus.tx_ready = !txf_full;
    assign bus.tx_level = txf_level;

    always_ff @(posedge clk) begin
        if (txf_push) txf_mem[txf_wptr[AW-1:0]] <= bus.tx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txf_wptr <= '0;
            txf_rptr <= '0;
        end else begin
            if (txf_push) txf_wptr <= txf_wptr + LW'(1);
            if (txf_pop)  txf_rptr <= txf_rptr + LW'(1);
        end
    end

    // ---------------- TX FSM ----------------
    logic [2:0]           tx_state;
    logic [3:0]           tx_phase;
    logic [BCW-1:0]       tx_bitcnt;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 tx_par;
    logic                 tx_q;
    logic                 tx_load;

    // A waiting byte is loaded either from IDLE or straight out of the last
    // stop tick, so queued frames follow each other without an idle gap.
    assign tx_load = tick && !txf_empty &&
                     ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_phase == 4'd15));
    assign txf_pop = tx_load;
    assign tx      = tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state  <= S_IDLE;
            tx_phase  <= '0;
            tx_bitcnt <= '0;
            tx_shreg  <= '0;
            tx_par    <= 1'b0;
            tx_q      <= 1'b1;
        end else if (tick) begin
            if (tx_load) begin
                tx_shreg  <= tx_head;
                tx_par    <= calc_parity(tx_head);
                tx_phase  <= '0;
                tx_bitcnt <= '0;
                tx_state  <= S_START;
                tx_q      <= 1'b0;
            end else begin
                case (tx_state)
                    S_IDLE: tx_q <= 1'b1;
                    S_START: begin
                        if (tx_phase == 4'd15) begin
                            tx_phase <= '0;
                            tx_state <= S_DATA;
                            tx_q     <= tx_shreg[0];
                        end else begin
                            tx_phase <= tx_phase + 4'd1;
                        end
                    end
                    S_DATA: begin
                        if (tx_phase == 4'd15) begin
                            tx_phase <= '0;
                            if (tx_bitcnt == LAST_BIT) begin
                                if (PARITY != 0) begin
                                    tx_state <= S_PARITY;
                                    tx_q     <= tx_par;
                                end else begin
                                    tx_state <= S_STOP;
                                    tx_q     <= 1'b1;
                                end
                            end else begin
                                tx_bitcnt <= tx_bitcnt + BCW'(1);
                                tx_shreg  <= tx_shreg >> 1;
                                tx_q      <= tx_shreg[1];
                            end
                        end else begin
                            tx_phase <= tx_phase + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        if (tx_phase == 4'd15) begin
                            tx_phase <= '0;
                            tx_state <= S_STOP;
                            tx_q     <= 1'b1;
                        end else begin
                            tx_phase <= tx_phase + 4'd1;
                        end
                    end
                    S_STOP: begin
                        if (tx_phase == 4'd15) begin
                            tx_phase <= '0;
                            tx_state <= S_IDLE;
                        end else begin
                            tx_phase <= tx_phase + 4'd1;
                        end
                        tx_q <= 1'b1;
                    end
                    default: begin
                        tx_state <= S_IDLE;
                        tx_q     <= 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- RX synchroniser ----------------
    logic [1:0] rx_sync;
    logic       rx_s;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_sync <= '1;
        else       rx_sync <= {rx_sync[0], rx};
    end

    // ---------------- RX FSM ----------------
    logic [2:0]           rx_state;
    logic [3:0]           rx_phase;
    logic [BCW-1:0]       rx_bitcnt;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_par;
    logic                 stop_sample, parity_ok, rx_commit;

    assign stop_sample = tick && (rx_state == S_STOP) && (rx_phase == 4'd15);
    assign parity_ok   = (PARITY == 0) || (rx_par == calc_parity(rx_shreg));
    assign rx_commit   = stop_sample && rx_s && parity_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state  <= S_IDLE;
            rx_phase  <= '0;
            rx_bitcnt <= '0;
            rx_shreg  <= '0;
            rx_par    <= 1'b0;
        end else if (tick) begin
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s) begin
                        rx_state <= S_START;
                        rx_phase <= '0;
                    end
                end
                S_START: begin
                    // Mid-bit re-check; a line already back high was a glitch.
                    if (rx_phase == 4'd7) begin
                        rx_phase  <= '0;
                        rx_bitcnt <= '0;
                        rx_state  <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_phase <= rx_phase + 4'd1;
                    end
                end
                S_DATA: begin
                    if (rx_phase == 4'd15) begin
                        rx_phase <= '0;
                        rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
                        if (rx_bitcnt == LAST_BIT)
                            rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            rx_bitcnt <= rx_bitcnt + BCW'(1);
                    end else begin
                        rx_phase <= rx_phase + 4'd1;
                    end
                end
                S_PARITY: begin
                    if (rx_phase == 4'd15) begin
                        rx_phase <= '0;
                        rx_par   <= rx_s;
                        rx_state <= S_STOP;
                    end else begin
                        rx_phase <= rx_phase + 4'd1;
                    end
                end
                S_STOP: begin
                    if (rx_phase == 4'd15) begin
                        rx_phase <= '0;
                        rx_state <= S_IDLE;
                    end else begin
                        rx_phase <= rx_phase + 4'd1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rxf_mem [FIFO_DEPTH];
    logic [LW-1:0]        rxf_wptr, rxf_rptr, rxf_level;
    logic                 rxf_full, rxf_empty, rxf_push, rxf_pop;

    assign rxf_level    = rxf_wptr - rxf_rptr;
    assign rxf_full     = (rxf_level == LW'(FIFO_DEPTH));
    assign rxf_empty    = (rxf_level == '0);
    assign rxf_pop      = bus.rx_ready && !rxf_empty;
    assign rxf_push     = rx_commit && (!rxf_full || rxf_pop);
    assign bus.rx_valid = !rxf_empty;
    assign bus.rx_data  = rxf_empty ? '0 : rxf_mem[rxf_rptr[AW-1:0]];
    assign bus.rx_level = rxf_level;

    always_ff @(posedge clk) begin
        if (rxf_push) rxf_mem[rxf_wptr[AW-1:0]] <= rx_shreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxf_wptr <= '0;
            rxf_rptr <= '0;
        end else begin
            if (rxf_push) rxf_wptr <= rxf_wptr + LW'(1);
            if (rxf_pop)  rxf_rptr <= rxf_rptr + LW'(1);
        end
    end

    // Status pulses: stop-bit error wins over parity, parity over overrun.
    logic frame_err_q, parity_err_q, overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_err_q  <= stop_sample && !rx_s;
            parity_err_q <= stop_sample && rx_s && !parity_ok;
            overrun_q    <= rx_commit && rxf_full && !rxf_pop;
        end
    end

    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_fifo_link.sv
// tb_uart_fifo_link: directed bench for uart_fifo_link.
// dut_a: 8N1, 16-deep FIFOs, optional tx->rx loopback.
// dut_b: 8E1, 4-deep FIFOs, rx driven directly by the bench.
// Both run at 16 clk cycles per bit (OVS_DIV = 1).
module tb_uart_fifo_link;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_a, tx_b;
    logic rx_a, rx_drv_a = 1'b1, rx_drv_b = 1'b1, loop_a = 1'b0;

    int checks = 0;
    int errors = 0;
    int perr_a = 0, ferr_a = 0, ovr_a = 0;
    int perr_b = 0, ferr_b = 0, ovr_b = 0;

    always #5 clk = ~clk;

    uart_fifo_link_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus_a ();
    uart_fifo_link_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  bus_b ();

    assign rx_a = loop_a ? tx_a : rx_drv_a;

    uart_fifo_link #(
        .CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)
    ) dut_a (
        .clk(clk), .reset(reset), .rx(rx_a), .tx(tx_a), .bus(bus_a)
    );

    uart_fifo_link #(
        .CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(reset), .rx(rx_drv_b), .tx(tx_b), .bus(bus_b)
    );

    // Pulse monitors: a pulse longer than one cycle counts more than once.
    always @(negedge clk) begin
        if (bus_a.parity_err) perr_a++;
        if (bus_a.frame_err)  ferr_a++;
        if (bus_a.overrun)    ovr_a++;
        if (bus_b.parity_err) perr_b++;
        if (bus_b.frame_err)  ferr_b++;
        if (bus_b.overrun)    ovr_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d);
        bus_a.tx_data  = d;
        bus_a.tx_valid = 1'b1;
        cyc(1);
        bus_a.tx_valid = 1'b0;
    endtask

    // Called right after the push edge: waits for the start bit, then
    // checks each of the 10 bit periods cycle by cycle.
    task automatic check_frame_a(input string name, input logic [7:0] d);
        int lat;
        logic [15:0] vec;
        logic [15:0] want;
        lat = 0;
        while (tx_a === 1'b1 && lat < 40) begin
            cyc(1);
            lat++;
        end
        check({name, "_start_lat"}, (lat >= 1 && lat <= 2) ? 1 : 0, 1);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 16; c++) begin
                vec[c] = tx_a;
                cyc(1);
            end
            if (b == 0)      want = 16'h0000;
            else if (b == 9) want = 16'hFFFF;
            else             want = d[b-1] ? 16'hFFFF : 16'h0000;
            check($sformatf("%s_bit%0d", name, b), {16'h0, vec}, {16'h0, want});
        end
        check({name, "_tx_level_end"}, 32'(bus_a.tx_level), 0);
        check({name, "_tx_idle"}, 32'(tx_a), 1);
    endtask

    // Drives one 8E1-style frame into dut_b; optionally raises rx_ready for
    // exactly the stop-sample cycle (10 cycles into the stop bit, given the
    // 2-flop synchroniser, tick detection and 8-tick start re-check).
    task automatic send_b(input logic [7:0] d, input logic pbit, input logic sbit,
                          input logic pop_at_stop);
        logic [10:0] bits;
        bits = {sbit, pbit, d, 1'b0};
        for (int j = 0; j < 11; j++) begin
            for (int c = 0; c < 16; c++) begin
                rx_drv_b = bits[j];
                bus_b.rx_ready = pop_at_stop && (j == 10) && (c == 10);
                cyc(1);
            end
        end
        rx_drv_b = 1'b1;
        bus_b.rx_ready = 1'b0;
        cyc(16);
    endtask

    task automatic pop_b(input string name, input logic [7:0] exp);
        check({name, "_valid"}, 32'(bus_b.rx_valid), 1);
        check({name, "_data"}, 32'(bus_b.rx_data), 32'(exp));
        bus_b.rx_ready = 1'b1;
        cyc(1);
        bus_b.rx_ready = 1'b0;
    endtask

    initial begin
        int p0, f0, o0;
        logic [7:0] d;
        logic [7:0] seq [4];
        bus_a.tx_data = '0; bus_a.tx_valid = 1'b0; bus_a.rx_ready = 1'b0;
        bus_b.tx_data = '0; bus_b.tx_valid = 1'b0; bus_b.rx_ready = 1'b0;

        // Reset values
        cyc(3);
        check("rst_tx", 32'(tx_a), 1);
        check("rst_tx_ready", 32'(bus_a.tx_ready), 1);
        check("rst_rx_valid", 32'(bus_a.rx_valid), 0);
        check("rst_rx_data", 32'(bus_a.rx_data), 0);
        check("rst_levels", {16'(bus_a.tx_level), 16'(bus_a.rx_level)}, 0);
        reset = 1'b0;
        cyc(4);
        check("post_rst_tx", 32'(tx_a), 1);

        // Single 8N1 frame 0xA5
        push_a(8'hA5);
        check("a5_tx_level", 32'(bus_a.tx_level), 1);
        check_frame_a("a5", 8'hA5);

        // Loopback, three back-to-back bytes
        loop_a = 1'b1;
        p0 = perr_a + ferr_a + ovr_a;
        cyc(2);
        bus_a.tx_valid = 1'b1;
        bus_a.tx_data = 8'h00; cyc(1);
        bus_a.tx_data = 8'hFF; cyc(1);
        bus_a.tx_data = 8'h3C; cyc(1);
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < 1200 && bus_a.rx_level != 5'd3; i++) cyc(1);
        check("loop_rx_level", 32'(bus_a.rx_level), 3);
        check("loop_no_err", perr_a + ferr_a + ovr_a - p0, 0);
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("loop_data%0d", i), 32'(bus_a.rx_data), 32'(seq[i]));
            bus_a.rx_ready = 1'b1;
            cyc(1);
            bus_a.rx_ready = 1'b0;
        end
        check("loop_empty", 32'(bus_a.rx_valid), 0);
        loop_a = 1'b0;
        cyc(20);

        // Even parity: 0x01 needs parity bit 1
        p0 = perr_b; f0 = ferr_b;
        send_b(8'h01, 1'b0, 1'b1, 1'b0);
        check("par_bad_pulse", perr_b - p0, 1);
        check("par_bad_level", 32'(bus_b.rx_level), 0);
        check("par_bad_noframe", ferr_b - f0, 0);
        p0 = perr_b;
        send_b(8'h01, 1'b1, 1'b1, 1'b0);
        check("par_ok_nopulse", perr_b - p0, 0);
        check("par_ok_level", 32'(bus_b.rx_level), 1);
        pop_b("par_ok", 8'h01);

        // Stop bit low on 0x55 (parity bit correct = 0)
        p0 = perr_b; f0 = ferr_b; o0 = ovr_b;
        send_b(8'h55, 1'b0, 1'b0, 1'b0);
        cyc(20);
        check("frm_pulse", ferr_b - f0, 1);
        check("frm_no_other", (perr_b - p0) + (ovr_b - o0), 0);
        check("frm_level", 32'(bus_b.rx_level), 0);

        // 4-cycle glitch on idle line
        f0 = ferr_b; p0 = perr_b; o0 = ovr_b;
        rx_drv_b = 1'b0; cyc(4);
        rx_drv_b = 1'b1; cyc(250);
        check("glitch_no_pulse", (ferr_b - f0) + (perr_b - p0) + (ovr_b - o0), 0);
        check("glitch_level", 32'(bus_b.rx_level), 0);

        // Fill the 4-deep RX FIFO, then overrun
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            d = seq[i];
            send_b(d, ^d, 1'b1, 1'b0);
        end
        check("fill_level", 32'(bus_b.rx_level), 4);
        check("fill_ready_unchanged", 32'(bus_b.rx_valid), 1);
        o0 = ovr_b;
        d = 8'h55;
        send_b(d, ^d, 1'b1, 1'b0);
        check("ovr_pulse", ovr_b - o0, 1);
        check("ovr_level", 32'(bus_b.rx_level), 4);

        // Pop exactly in the stop-sample cycle: push accepted, no overrun
        o0 = ovr_b;
        d = 8'h66;
        send_b(d, ^d, 1'b1, 1'b1);
        check("pop_at_stop_no_ovr", ovr_b - o0, 0);
        check("pop_at_stop_level", 32'(bus_b.rx_level), 4);
        pop_b("drain0", 8'h22);
        pop_b("drain1", 8'h33);
        pop_b("drain2", 8'h44);
        pop_b("drain3", 8'h66);
        check("drain_empty", 32'(bus_b.rx_level), 0);

        // Reset in the middle of data bit 3 of 0xC3 (bit 3 = 0)
        bus_a.tx_valid = 1'b1;
        bus_a.tx_data = 8'hC3; cyc(1);
        bus_a.tx_data = 8'h81; cyc(1);
        bus_a.tx_valid = 1'b0;
        for (int i = 0; i < 40 && tx_a === 1'b1; i++) cyc(1);
        cyc(16 + 48 + 8);
        check("pre_rst_bit3", 32'(tx_a), 0);
        check("pre_rst_level", 32'(bus_a.tx_level), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx_a), 1);
        check("mid_rst_levels", {16'(bus_a.tx_level), 16'(bus_a.rx_level)}, 0);
        @(posedge clk);
        cyc(2);
        reset = 1'b0;
        cyc(3);
        check("after_rst_idle", 32'(tx_a), 1);
        push_a(8'h5A);
        check_frame_a("post_rst", 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_fifo_link.md
Name: uart_fifo_link

Overview:
Parametrised full-duplex UART link with TX and RX FIFOs, configurable frame format and error reporting. It is the successor of the fixed 8N1 board-to-board UART used between Basys 3 boards and the PC. It sits between the pins (RsRx/RsTx or JA0/JA1) and the text/display logic. Byte streams cross it on valid/ready handshakes instead of single-cycle strobes, so no byte is lost while the consumer is busy.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bits/s
DATA_BITS, 8, payload bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
FIFO_DEPTH, 16, entries per FIFO, power of 2, minimum 2

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
rx  in  1  serial input, asynchronous to clk
tx  out  1  serial output, idle high
tx_data  in  DATA_BITS  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO not full
rx_data  out  DATA_BITS  head of RX FIFO (show-ahead)
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  consumer accepts rx_data
parity_err  out  1  one-cycle pulse: received frame had bad parity
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: received byte dropped because RX FIFO full
tx_level  out  clog2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_level  out  clog2(FIFO_DEPTH)+1  RX FIFO occupancy

Behaviour:
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, all pulses 0, levels 0. Both FSMs go to IDLE, FIFOs empty, tick counter 0. Reset mid-frame aborts the frame; tx goes high immediately.
- Tick: OVS_DIV = floor(CLK_HZ/(BAUD*16)), minimum 1. A free-running counter counts 0..OVS_DIV-1 and pulses tick for one cycle at OVS_DIV-1. TX and RX share the tick. One bit lasts 16 ticks.
- FIFOs: circular buffers with one extra pointer bit.
  - Push is accepted when not full, or when a pop occurs in the same cycle.
  - Pop on empty is ignored.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TX handshake: write occurs when tx_valid and tx_ready are both high. tx_valid while full is held off, with no side effect.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE pops the FIFO head on the first tick while the FIFO is non-empty.
  - START drives 0 for 16 ticks.
  - DATA drives the payload LSB first, DATA_BITS x 16 ticks.
  - PARITY is present only if PARITY != 0 and lasts 16 ticks. Odd parity: XOR of data, inverted. Even parity: XOR of data.
  - STOP drives 1 for 16 ticks, then returns to IDLE. Back-to-back frames run with no extra idle bit.
- RX sync: rx passes through a 2-flop synchroniser before any use.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE detects the synchronised line low on a tick.
  - START samples after 8 ticks (mid-bit). If the line is high, the start is treated as a glitch and the FSM returns to IDLE with no error.
  - Each later bit is sampled every 16 ticks at mid-bit.
  - STOP is sampled at mid-bit, and the FSM returns to IDLE immediately after sampling so a following start edge is caught.
- RX commit, evaluated at the stop-bit sample, in priority order:
  1. Stop bit low: frame_err pulses and the byte is discarded.
  2. Otherwise, parity mismatch: parity_err pulses and the byte is discarded.
  3. Otherwise, the FIFO is full and no pop occurs this cycle: overrun pulses and the byte is discarded.
  4. Otherwise, the byte is pushed.
  - At most one of the three pulses fires per frame.
- RX handshake: pop occurs when rx_valid and rx_ready are both high. rx_data updates to the next entry in the cycle after the pop.
- Latencies:
  - Push into an idle, empty TX FIFO: tx falls within OVS_DIV+1 cycles.
  - Stop-bit sample to rx_valid high: 1 cycle.
- Widths: shift registers are DATA_BITS wide. Bit counters are clog2(DATA_BITS)+1 bits. The tick-phase counter is 4 bits and wraps 15 -> 0.

Test Plan:
All scenarios use CLK_HZ=1600000 and BAUD=100000, giving OVS_DIV=1 and 16 clk cycles per bit.
- Reset, then push 0xA5 with PARITY=0 -> tx reads 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1, then 1 for 16 cycles; tx_level returns to 0.
- Loop tx to rx, push 0x00, 0xFF and 0x3C back-to-back -> rx_data pops 0x00, 0xFF, 0x3C in order, with no error pulses.
- PARITY=2, drive a frame 0x01 with the parity bit 0 -> parity_err pulses once, rx_level stays 0. Repeat with the parity bit 1 -> byte accepted.
- Drive a frame 0x55 with the stop bit 0 -> frame_err pulses once, and nothing is pushed. A 4-cycle low glitch on idle rx -> no pulses and no push.
- With FIFO_DEPTH=4 and rx_ready=0, send 5 frames -> rx_level=4 and overrun pulses on the 5th. With rx_ready=1 exactly in the 5th stop-sample cycle -> no overrun and level stays 4.
- Assert reset mid DATA bit 3 of a TX frame -> tx=1 asynchronously, and the levels are 0. After release, the next push sends a complete, correct frame.
